// File: rtl/mm_ctx_interleaved.sv
// Multi-context Montgomery multiplier: up to NUM_CTX tagged jobs share one
// radix-2^R round datapath, serviced round-robin by a free-running pointer.
// Result is a*b*2^(-W) mod m, fully reduced; jobs may complete out of order.
module mm_ctx_interleaved #(
  parameter int unsigned W       = 64,
  parameter int unsigned R       = 8,
  parameter int unsigned NUM_CTX = 4,
  parameter int unsigned TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [W-1:0]     m,
  input  logic [R-1:0]     m_prime,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_c,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic             full,
  output logic             done
);

  localparam int unsigned ROUNDS = W / R;
  localparam int unsigned RND_W  = $clog2(ROUNDS) + 1;
  localparam int unsigned PTR_W  = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
  localparam int unsigned CW     = W + 1;
  localparam int unsigned TW     = W + R + 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_FINAL   = 2'd2,
    S_DONE    = 2'd3
  } ctx_state_t;

  ctx_state_t       r_state [NUM_CTX];
  logic [W-1:0]     r_a     [NUM_CTX];
  logic [W-1:0]     r_b     [NUM_CTX];
  logic [CW-1:0]    r_c     [NUM_CTX];
  logic [TAG_W-1:0] r_tag   [NUM_CTX];
  logic [RND_W-1:0] r_rnd   [NUM_CTX];
  logic [PTR_W-1:0] r_ptr;
  logic             r_done;

  logic [NUM_CTX-1:0] w_idle_vec;
  logic [NUM_CTX-1:0] w_done_vec;
  logic [PTR_W-1:0]   w_acc_idx;
  logic [PTR_W-1:0]   w_out_idx;
  logic               w_any_idle;
  logic               w_any_done;
  logic               w_accept;
  logic               w_pop;

  logic [CW-1:0]      w_srv_c;
  logic [TW-1:0]      w_t;
  logic [R-1:0]       w_q;
  logic [TW-1:0]      w_sum;
  logic [CW-1:0]      w_c_round;
  logic [CW-1:0]      w_c_final;

  // Lowest-index IDLE context takes new jobs; lowest-index DONE context drives the output.
  always_comb begin
    w_idle_vec = '0;
    w_done_vec = '0;
    w_acc_idx  = '0;
    w_out_idx  = '0;
    for (int i = int'(NUM_CTX) - 1; i >= 0; i--) begin
      if (r_state[i] == S_IDLE) begin
        w_idle_vec[i] = 1'b1;
        w_acc_idx     = PTR_W'(i);
      end
      if (r_state[i] == S_DONE) begin
        w_done_vec[i] = 1'b1;
        w_out_idx     = PTR_W'(i);
      end
    end
  end

  assign w_any_idle = |w_idle_vec;
  assign w_any_done = |w_done_vec;
  assign w_accept   = in_valid & w_any_idle;
  assign w_pop      = out_ready & w_any_done;

  assign in_ready  = w_any_idle;
  assign full      = ~w_any_idle;
  assign busy      = ~&w_idle_vec;
  assign out_valid = w_any_done;
  assign out_c     = w_any_done ? r_c[w_out_idx][W-1:0] : '0;
  assign out_tag   = w_any_done ? r_tag[w_out_idx] : '0;
  assign done      = r_done;

  // Shared round datapath, operating on the context under the service pointer.
  assign w_srv_c   = r_c[r_ptr];
  assign w_t       = TW'(w_srv_c) + TW'(r_a[r_ptr][R-1:0]) * TW'(r_b[r_ptr]);
  assign w_q       = w_t[R-1:0] * m_prime;
  assign w_sum     = w_t + TW'(w_q) * TW'(m);
  assign w_c_round = CW'(w_sum >> R);
  assign w_c_final = (w_srv_c >= CW'(m)) ? (w_srv_c - CW'(m)) : w_srv_c;

  // Per-context state machines, round-robin pointer and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr  <= '0;
      r_done <= 1'b0;
      for (int i = 0; i < int'(NUM_CTX); i++) begin
        r_state[i] <= S_IDLE;
        r_a[i]     <= '0;
        r_b[i]     <= '0;
        r_c[i]     <= '0;
        r_tag[i]   <= '0;
        r_rnd[i]   <= '0;
      end
    end else begin
      r_ptr  <= (r_ptr == PTR_W'(NUM_CTX - 1)) ? '0 : r_ptr + 1'b1;
      r_done <= 1'b0;
      for (int i = 0; i < int'(NUM_CTX); i++) begin
        case (r_state[i])
          S_IDLE: begin
            if (w_accept && (w_acc_idx == PTR_W'(i))) begin
              r_a[i]     <= in_a;
              r_b[i]     <= in_b;
              r_c[i]     <= '0;
              r_tag[i]   <= in_tag;
              r_rnd[i]   <= '0;
              r_state[i] <= S_COMPUTE;
            end
          end
          S_COMPUTE: begin
            if (r_ptr == PTR_W'(i)) begin
              if (r_rnd[i] == RND_W'(ROUNDS)) begin
                r_state[i] <= S_FINAL;
              end else begin
                r_c[i]   <= w_c_round;
                r_a[i]   <= r_a[i] >> R;
                r_rnd[i] <= r_rnd[i] + 1'b1;
              end
            end
          end
          S_FINAL: begin
            if (r_ptr == PTR_W'(i)) begin
              r_c[i]     <= w_c_final;
              r_state[i] <= S_DONE;
              r_done     <= 1'b1;
            end
          end
          S_DONE: begin
            if (w_pop && (w_out_idx == PTR_W'(i))) begin
              r_state[i] <= S_IDLE;
            end
          end
          default: r_state[i] <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/mm_ctx_interleaved.md
Name: mm_ctx_interleaved

Overview:
- Parametrised, multi-context successor to the pipelined Montgomery multiplier top.
- Holds up to NUM_CTX independent jobs and interleaves them through one shared radix-2^R Montgomery round datapath.
- Computes out_c = a*b*2^(-W) mod m, fully reduced.
- Jobs enter and leave on valid/ready handshakes. Each job carries a tag, so results may complete out of order.

Parameters:
W, 64, operand/modulus width; must be a multiple of R
R, 8, digit width per round; W/R rounds per job
NUM_CTX, 4, number of job contexts (>=2)
TAG_W, 4, job tag width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  job offered
in_ready  out  1  a context is IDLE
in_a  in  W  multiplicand, must be < m
in_b  in  W  multiplier, must be < m
in_tag  in  TAG_W  job tag
m  in  W  odd modulus, held stable while busy
m_prime  in  R  -m^(-1) mod 2^R, held stable while busy
out_valid  out  1  a context is DONE
out_ready  in  1  consumer accepts result
out_c  out  W  result, < m
out_tag  out  TAG_W  tag of the result
busy  out  1  any context not IDLE
full  out  1  no context IDLE
done  out  1  one-cycle pulse when any context enters DONE

Behaviour:
- Reset (asynchronous, rst=1): all contexts IDLE, ptr=0, all per-context registers 0. Outputs: in_ready=1, out_valid=0, out_c=0, out_tag=0, busy=0, full=0, done=0.
- Context state per slot: IDLE -> COMPUTE -> FINAL -> DONE -> IDLE. Per-context registers: A (W), B (W), C (W+1), tag, rnd (log2(W/R)+1 bits).
- Accept:
  - Handshake is in_valid & in_ready.
  - The lowest-index IDLE context loads A=in_a, B=in_b, C=0, tag=in_tag, rnd=0, and moves to COMPUTE on the next edge.
  - in_ready = any IDLE, decoded from registered state. A context freed this cycle cannot be refilled in the same cycle.
- Service pointer: ptr increments by 1 mod NUM_CTX every cycle, unconditionally. Only context[ptr] is serviced in a given cycle.
- COMPUTE service (one round):
  - a_i = A[R-1:0]
  - t = C + a_i*B, width W+R+2
  - q = (t[R-1:0]*m_prime) mod 2^R
  - C <= (t + q*m) >> R
  - A <= A >> R; rnd <= rnd+1
  - When rnd reaches W/R, the context moves to FINAL.
  - Invariant: C < 2m.
- FINAL service: if C >= m then C <= C - m; the context moves to DONE. done pulses in the cycle after this edge.
- Output:
  - out_valid = any DONE.
  - out_c and out_tag come from the lowest-index DONE context, and are 0 when out_valid=0.
  - On out_valid & out_ready, that context moves to IDLE.
  - A DONE context holds its result indefinitely under back-pressure. Other contexts keep computing.
- Simultaneous events: accept and output in the same cycle is legal and always targets different contexts. Accept, output and service of three distinct contexts in the same cycle are all independent.
- Status: full = ~in_ready; busy = any non-IDLE.
- Latency: from accept to out_valid is between NUM_CTX*(W/R+1)+1 and NUM_CTX*(W/R+2) cycles. The window depends on ptr phase and does not depend on load from other contexts.
- Reset asserted mid-operation discards all jobs immediately; no partial output is produced.
- Changing m or m_prime while busy gives undefined results but no hang; every job still reaches DONE.

Test Plan:
Parameters for all scenarios: W=64, R=8, NUM_CTX=4, m=0xFFFFFFFFFFFFFFC5, m_prime=0xF3.
1. Reset, then a=59 (=2^64 mod m), b=12345, tag=3 -> out_c=12345, out_tag=3, done pulses once, latency within [37,40] cycles, busy drops after the out handshake.
2. a=59, b=0xFFFFFFFFFFFFFFC4 and a=0, b=0x1234 -> 0xFFFFFFFFFFFFFFC4 and 0. The first case exercises the FINAL subtract boundary.
3. Issue 5 jobs back-to-back with out_ready=0 (tags 0-4, a=59, b=tag+1) -> in_ready=0 and full=1 after the 4th accept. The 5th job stalls until out_ready=1 and one result drains. All 5 tags return with out_c=tag+1.
4. out_ready toggled randomly during 100 random jobs (random a,b < m) -> every tag returns exactly once, and each result matches the model a*b*2^(-64) mod m.
5. Accept and output handshakes in the same cycle -> both complete, and the freed context is not reused until the next cycle.
6. Assert rst during 4 active jobs -> outputs return to their reset values asynchronously. No out_valid appears afterwards, and new jobs compute correctly.
